led_pattern_driver: RTL

Sequential, parametrised successor to the board's combinational LED decode path. It accepts LED patterns through a valid/ready handshake and double-buffers them, swapping only on prescaler tick boundaries. Patterns are displayed in static, blink, chase or off mode, with PWM brightness and selectable output polarity. It sits between the game/state logic and the LED pins.

---
 rtl/led_pattern_driver.sv | 98 +++++++++
 1 files changed

// File: rtl/led_pattern_driver.sv
// led_pattern_driver: double-buffered LED pattern driver with tick-aligned swap, blink/chase modes and PWM dimming
module led_pattern_driver #(
  parameter int N_LED      = 17,
  parameter bit ACTIVE_LOW = 1,
  parameter int PRESC_W    = 16,
  parameter int PWM_W      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_LED-1:0]   pattern_in,
  input  logic               pattern_vld,
  output logic               pattern_rdy,
  input  logic [1:0]         mode,
  input  logic [PRESC_W-1:0] presc_max,
  input  logic [PWM_W-1:0]   duty,
  output logic [N_LED-1:0]   led_out,
  output logic               tick_out
);
  typedef enum logic [1:0] {STATIC = 2'b00, BLINK = 2'b01, CHASE = 2'b10, OFF = 2'b11} mode_t;
  logic [PRESC_W-1:0] presc_cnt;
  logic [PWM_W-1:0]   pwm_cnt;
  logic [N_LED-1:0]   pending;
  logic [N_LED-1:0]   active;
  logic [N_LED-1:0]   pos;
  logic [N_LED-1:0]   lit;
  logic               pend_full;
  logic               phase;
  logic               tick;
  logic               pwm_en;
  mode_t              mode_q;
  mode_t              mode_in;
  assign mode_in     = mode_t'(mode);
  // a count already past a lowered presc_max still ticks on the next compare
  assign tick        = presc_cnt >= presc_max;
  assign pwm_en      = pwm_cnt < duty;
  assign pattern_rdy = ~pend_full;
  // select the lit vector from the registered mode and sequence state
  always_comb begin
    lit = '0;
    case (mode_q)
      STATIC:  lit = active & {N_LED{pwm_en}};
      BLINK:   lit = active & {N_LED{phase & pwm_en}};
      CHASE:   lit = active & pos & {N_LED{pwm_en}};
      default: lit = '0;
    endcase
  end
  // prescaler: wraps to zero on tick, tick pulse is exported one cycle late
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
      tick_out  <= 1'b0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);
      tick_out  <= tick;
    end
  end
  // free-running PWM counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + PWM_W'(1);
  end
  // double buffer: accept into pending when empty, swap to active only on a tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      pend_full <= 1'b0;
      active    <= '0;
    end else if (pattern_vld && !pend_full) begin
      pending   <= pattern_in;
      pend_full <= 1'b1;
    end else if (tick && pend_full) begin
      active    <= pending;
      pend_full <= 1'b0;
    end
  end
  // blink phase and chase position; a mode change restarts them and beats a tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= STATIC;
      phase  <= 1'b1;
      pos    <= N_LED'(1);
    end else begin
      mode_q <= mode_in;
      if (mode_in != mode_q) begin
        phase <= 1'b1;
        pos   <= N_LED'(1);
      end else if (tick && mode_q != OFF) begin
        phase <= ~phase;
        pos   <= {pos[N_LED-2:0], pos[N_LED-1]};
      end
    end
  end
  // registered pin drive with selectable polarity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_out <= {N_LED{ACTIVE_LOW}};
    else        led_out <= ACTIVE_LOW ? ~lit : lit;
  end
endmodule
